lsu_bus_master: RTL and testbench
=================================

Name: lsu_bus_master

Overview:
- Load/store unit (LSU) that services the LSU request raised by the instruction decoder (lsu_VALID when a store is decoded or write-back selects memory).
- Captures address, store data and funct3, then runs a req/gnt/rvalid transaction on the data-memory bus.
- Aligns and sign/zero-extends load data, and stalls the core until the access completes or faults.
- Sits between the execute stage (ALU address, rs2 data) and the data memory/peripheral bus.

Parameters:
- TIMEOUT_CYC, 255: cycles allowed in REQ+RESP before the access is aborted with an error; range 1..65535.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- lsu_VALID  in  1  LSU request from decoder
- i_st_mem  in  1  1=store, 0=load
- i_funct3  in  3  access size/sign (RV32I load/store funct3)
- i_addr  in  32  byte address from ALU
- i_st_data  in  32  rs2 value
- o_stall  out  1  hold pipeline
- o_done  out  1  one-cycle completion pulse
- o_err  out  1  valid with o_done: misaligned, illegal funct3 or timeout
- o_ld_data  out  32  formatted load result
- o_mem_req  out  1  bus request
- o_mem_we  out  1  bus write enable
- o_mem_addr  out  32  word address ({addr[31:2],2'b00})
- o_mem_be  out  4  byte enables
- o_mem_wdata  out  32  lane-replicated store data
- i_mem_gnt  in  1  request accepted
- i_mem_rvalid  in  1  response valid (loads and stores)
- i_mem_rdata  in  32  read word

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; all outputs 0; timeout counter 0. Asserting reset mid-transaction drops o_mem_req immediately; a later rvalid is ignored.
- States: IDLE, REQ, RESP, DONE.
- IDLE, lsu_VALID=1: check the request. The request is illegal on any of:
  - load funct3 in {011,110,111};
  - store funct3 > 010;
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0.
- Illegal request: go to DONE with error flag set; no bus request is issued.
- Legal request: register addr, funct3, we, be and wdata; clear the counter; go to REQ.
- REQ: o_mem_req=1. Address, we, be and wdata stay stable until i_mem_gnt. On gnt, go to RESP; o_mem_req drops the next cycle.
- RESP: wait for i_mem_rvalid. If rvalid arrives in the same cycle as gnt, it is ignored; rvalid is sampled only in RESP. On rvalid, register the formatted load data (stores: 0) and go to DONE.
- Timeout: the counter increments each cycle in REQ/RESP. When counter==TIMEOUT_CYC-1 without the exit event, go to DONE with error flag set, o_ld_data=0, o_mem_req deasserted.
- DONE (exactly one cycle): o_done=1; o_err=flag; then go to IDLE. lsu_VALID is ignored in DONE because it still belongs to the retiring instruction.
- o_stall (combinational) = (IDLE & lsu_VALID) | REQ | RESP. It is 0 in DONE so the pipeline advances at the end of that cycle. The minimum LSU access latency is 3 cycles (IDLE→REQ→RESP→DONE with gnt and rvalid both immediate).
- Byte enables and store data, with lane n=addr[1:0]:
  - byte: be=4'b0001<<n, wdata={4{st_data[7:0]}};
  - half: be=4'b0011<<n, wdata={2{st_data[15:0]}};
  - word: be=4'b1111, wdata=st_data.
  - Loads drive the same be; we=0.
- Load format: select byte rdata[8n+7:8n] or half rdata[16*addr[1]+15:16*addr[1]].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
- o_ld_data holds its value until the next DONE.
- Back-to-back: a new lsu_VALID in the cycle after DONE is accepted normally.

Test Plan:
- lw addr=0x100, gnt and rvalid immediate, rdata=0xDEADBEEF → o_mem_addr=0x100, be=1111, stall for 3 cycles, o_done pulse with o_ld_data=0xDEADBEEF, o_err=0.
- lb addr=0x203, rdata=0x80FF_0000 → be=1000, o_ld_data=0xFFFFFF80. Same access as lbu → 0x00000080.
- sh addr=0x12, st_data=0x1234ABCD, gnt delayed 4 cycles → req held stable with addr=0x10, be=1100, wdata=0xABCDABCD, we=1; o_done after rvalid, o_ld_data=0.
- lw addr=0x102 → no o_mem_req; o_done=1 and o_err=1 on the next cycle; stall for 1 cycle. sw with funct3=011 → same response.
- TIMEOUT_CYC=8, gnt given, rvalid never arrives → o_done with o_err=1 and o_ld_data=0 exactly 8 cycles after entering REQ; a late rvalid is ignored.
- Reset asserted while in RESP → o_mem_req, o_stall, o_done all 0 immediately; after release, a lw completes normally.

Source files
------------

// File: rtl/lsu_bus_master_if.sv
// Bundles the request/stall signals from the decoder with the data-memory bus.
// The master modport is the LSU side; the slave modport is the pipeline/memory side.
interface lsu_bus_master_if;
  logic        lsu_VALID;
  logic        i_st_mem;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_st_data;
  logic        o_stall;
  logic        o_done;
  logic        o_err;
  logic [31:0] o_ld_data;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_wdata;
  logic        i_mem_gnt;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;

  modport master (
    input  lsu_VALID, i_st_mem, i_funct3, i_addr, i_st_data,
    input  i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    output o_stall, o_done, o_err, o_ld_data,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata
  );

  modport slave (
    output lsu_VALID, i_st_mem, i_funct3, i_addr, i_st_data,
    output i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    input  o_stall, o_done, o_err, o_ld_data,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata
  );
endinterface

// File: rtl/lsu_bus_master.sv
// Load/store unit: validates the decoder's request, runs one req/gnt/rvalid
// data-bus access, and returns aligned, sign/zero-extended load data.
module lsu_bus_master #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  lsu_bus_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] ld_data_q, ld_data_d;

  logic        illegal;
  logic [1:0]  lane;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ld_fmt;
  logic        timeout;

  assign lane    = bus.i_addr[1:0];
  assign timeout = (cnt_q == TO_LAST);

  always_comb begin
    illegal = 1'b0;
    if (bus.i_st_mem) illegal = (bus.i_funct3 > 3'b010);
    else              illegal = (bus.i_funct3 == 3'b011) || (bus.i_funct3[2:1] == 2'b11);
    if (bus.i_funct3[1:0] == 2'b01 && lane[0])        illegal = 1'b1;
    if (bus.i_funct3[1:0] == 2'b10 && lane != 2'b00)  illegal = 1'b1;
  end

  // Store data is replicated across lanes so the byte enables alone select the target.
  always_comb begin
    req_be    = 4'b1111;
    req_wdata = bus.i_st_data;
    case (bus.i_funct3[1:0])
      2'b00: begin
        req_be    = 4'b0001 << lane;
        req_wdata = {4{bus.i_st_data[7:0]}};
      end
      2'b01: begin
        req_be    = 4'b0011 << lane;
        req_wdata = {2{bus.i_st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (addr_q[1:0])
      2'b00:   rd_byte = bus.i_mem_rdata[7:0];
      2'b01:   rd_byte = bus.i_mem_rdata[15:8];
      2'b10:   rd_byte = bus.i_mem_rdata[23:16];
      default: rd_byte = bus.i_mem_rdata[31:24];
    endcase
    rd_half = addr_q[1] ? bus.i_mem_rdata[31:16] : bus.i_mem_rdata[15:0];
    ld_fmt  = '0;
    if (!we_q) begin
      case (funct3_q)
        3'b000:  ld_fmt = {{24{rd_byte[7]}}, rd_byte};
        3'b001:  ld_fmt = {{16{rd_half[15]}}, rd_half};
        3'b010:  ld_fmt = bus.i_mem_rdata;
        3'b100:  ld_fmt = {24'd0, rd_byte};
        3'b101:  ld_fmt = {16'd0, rd_half};
        default: ld_fmt = '0;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    funct3_d  = funct3_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    ld_data_d = ld_data_q;
    case (state_q)
      IDLE: begin
        if (bus.lsu_VALID) begin
          if (illegal) begin
            state_d   = DONE;
            err_d     = 1'b1;
            ld_data_d = '0;
          end else begin
            state_d  = REQ;
            addr_d   = bus.i_addr;
            funct3_d = bus.i_funct3;
            we_d     = bus.i_st_mem;
            be_d     = req_be;
            wdata_d  = req_wdata;
            cnt_d    = '0;
            err_d    = 1'b0;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + 16'd1;
        if (bus.i_mem_gnt) begin
          state_d = RESP;
        end else if (timeout) begin
          state_d   = DONE;
          err_d     = 1'b1;
          ld_data_d = '0;
        end
      end
      RESP: begin
        cnt_d = cnt_q + 16'd1;
        if (bus.i_mem_rvalid) begin
          state_d   = DONE;
          ld_data_d = ld_fmt;
        end else if (timeout) begin
          state_d   = DONE;
          err_d     = 1'b1;
          ld_data_d = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      funct3_q  <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      ld_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      funct3_q  <= funct3_d;
      we_q      <= we_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      ld_data_q <= ld_data_d;
    end
  end

  // Bus qualifiers are forced low outside REQ so an idle bus carries no stale write.
  assign bus.o_mem_req   = (state_q == REQ);
  assign bus.o_mem_we    = bus.o_mem_req & we_q;
  assign bus.o_mem_addr  = bus.o_mem_req ? {addr_q[31:2], 2'b00} : '0;
  assign bus.o_mem_be    = bus.o_mem_req ? be_q : '0;
  assign bus.o_mem_wdata = bus.o_mem_req ? wdata_q : '0;
  assign bus.o_stall     = ((state_q == IDLE) && bus.lsu_VALID) ||
                           (state_q == REQ) || (state_q == RESP);
  assign bus.o_done      = (state_q == DONE);
  assign bus.o_err       = (state_q == DONE) & err_q;
  assign bus.o_ld_data   = ld_data_q;
endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed bench for lsu_bus_master: a memory responder model, a bus-field
// monitor and a completion monitor checking against queued expectations.
module tb_lsu_bus_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_bus_master_if bus();

  lsu_bus_master #(.TIMEOUT_CYC(8)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic        err;
    logic [31:0] ld;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  resp_t resp_q[$];
  bus_t  bus_q[$];
  int    checks = 0;
  int    errors = 0;

  int          cfg_gnt_delay = 0;
  logic [31:0] cfg_rdata     = '0;
  bit          cfg_no_rvalid = 1'b0;
  bit          rsp_pending   = 1'b0;
  int          wait_n        = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: grants after cfg_gnt_delay request cycles, answers the next cycle.
  initial begin
    bus.i_mem_gnt    = 1'b0;
    bus.i_mem_rvalid = 1'b0;
    bus.i_mem_rdata  = '0;
    forever begin
      @(negedge clk);
      bus.i_mem_gnt    = 1'b0;
      bus.i_mem_rvalid = 1'b0;
      if (rsp_pending) begin
        rsp_pending = 1'b0;
        if (!cfg_no_rvalid) begin
          bus.i_mem_rvalid = 1'b1;
          bus.i_mem_rdata  = cfg_rdata;
        end
      end else if (bus.o_mem_req) begin
        if (wait_n >= cfg_gnt_delay) begin
          bus.i_mem_gnt = 1'b1;
          wait_n        = 0;
          rsp_pending   = 1'b1;
        end else begin
          wait_n++;
        end
      end else begin
        wait_n = 0;
      end
    end
  end

  // Bus monitor: every request cycle must present the queued fields unchanged.
  initial begin
    bus_t e;
    forever begin
      @(negedge clk);
      #1;
      if (bus.o_mem_req) begin
        if (bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got addr %h expected no request", bus.o_mem_addr);
        end else begin
          e = bus_q[0];
          chk("mem_addr", bus.o_mem_addr, e.addr);
          chk("mem_we", 32'(bus.o_mem_we), 32'(e.we));
          chk("mem_be", 32'(bus.o_mem_be), 32'(e.be));
          if (e.we) chk("mem_wdata", bus.o_mem_wdata, e.wdata);
          if (bus.i_mem_gnt) void'(bus_q.pop_front());
        end
      end
    end
  end

  // Completion monitor.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      #1;
      if (bus.o_done) begin
        if (resp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got err=%0b ld=%h expected no completion",
                   bus.o_err, bus.o_ld_data);
        end else begin
          r = resp_q.pop_front();
          chk("done_err", 32'(bus.o_err), 32'(r.err));
          chk("done_ld_data", bus.o_ld_data, r.ld);
          $display("txn done: err=%0b ld_data=%h", bus.o_err, bus.o_ld_data);
        end
      end
    end
  end

  task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] sdata, input int gdel, input logic [31:0] rdata,
                       input bit norv, input bit nognt, input bit exp_bus, input bit exp_err,
                       input logic [31:0] exp_ld, input logic [3:0] exp_be,
                       input logic [31:0] exp_wdata, input int exp_stall);
    bus_t  b;
    resp_t r;
    int    n;
    cfg_gnt_delay = gdel;
    cfg_rdata     = rdata;
    cfg_no_rvalid = norv;
    r.err = exp_err;
    r.ld  = exp_ld;
    resp_q.push_back(r);
    if (exp_bus) begin
      b.addr  = {addr[31:2], 2'b00};
      b.we    = st;
      b.be    = exp_be;
      b.wdata = exp_wdata;
      bus_q.push_back(b);
    end
    @(negedge clk);
    bus.lsu_VALID = 1'b1;
    bus.i_st_mem  = st;
    bus.i_funct3  = f3;
    bus.i_addr    = addr;
    bus.i_st_data = sdata;
    #1;
    n = 0;
    while (bus.o_stall && n < 100) begin
      n++;
      @(negedge clk);
      bus.lsu_VALID = 1'b0;
      #1;
    end
    $display("txn issue: st=%0b f3=%0d addr=%h stall_cycles=%0d", st, f3, addr, n);
    chk("stall_cycles", 32'(n), 32'(exp_stall));
    if (nognt && bus_q.size() > 0) void'(bus_q.pop_front());
    chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.lsu_VALID = 1'b0;
    bus.i_st_mem  = 1'b0;
    bus.i_funct3  = '0;
    bus.i_addr    = '0;
    bus.i_st_data = '0;
    #1;
    chk("rst_req", 32'(bus.o_mem_req), 32'd0);
    chk("rst_stall", 32'(bus.o_stall), 32'd0);
    chk("rst_done", 32'(bus.o_done), 32'd0);
    chk("rst_err", 32'(bus.o_err), 32'd0);
    chk("rst_ld_data", bus.o_ld_data, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    //    st f3    addr          sdata         gd rdata         nrv ngn bus err exp_ld        be       wdata         stall
    issue(0, 3'd2, 32'h0000_0100, 32'h0,        0, 32'hDEADBEEF, 0, 0, 1, 0, 32'hDEADBEEF, 4'b1111, 32'h0,        3);
    issue(0, 3'd0, 32'h0000_0203, 32'h0,        0, 32'h80FF0000, 0, 0, 1, 0, 32'hFFFFFF80, 4'b1000, 32'h0,        3);
    issue(0, 3'd4, 32'h0000_0203, 32'h0,        0, 32'h80FF0000, 0, 0, 1, 0, 32'h00000080, 4'b1000, 32'h0,        3);
    issue(1, 3'd1, 32'h0000_0012, 32'h1234ABCD, 4, 32'h55555555, 0, 0, 1, 0, 32'h0,        4'b1100, 32'hABCDABCD, 7);
    issue(0, 3'd1, 32'h0000_0002, 32'h0,        0, 32'h80017FFF, 0, 0, 1, 0, 32'hFFFF8001, 4'b1100, 32'h0,        3);
    issue(0, 3'd5, 32'h0000_0000, 32'h0,        0, 32'h80017FFF, 0, 0, 1, 0, 32'h00007FFF, 4'b0011, 32'h0,        3);
    issue(1, 3'd0, 32'h0000_0001, 32'h000000A5, 0, 32'h0,        0, 0, 1, 0, 32'h0,        4'b0010, 32'hA5A5A5A5, 3);
    issue(1, 3'd2, 32'h0000_0040, 32'h01020304, 1, 32'h0,        0, 0, 1, 0, 32'h0,        4'b1111, 32'h01020304, 4);
    issue(0, 3'd2, 32'h0000_0102, 32'h0,        0, 32'h0,        0, 0, 0, 1, 32'h0,        4'b0000, 32'h0,        1);
    issue(1, 3'd3, 32'h0000_0200, 32'h0,        0, 32'h0,        0, 0, 0, 1, 32'h0,        4'b0000, 32'h0,        1);
    issue(0, 3'd1, 32'h0000_0005, 32'h0,        0, 32'h0,        0, 0, 0, 1, 32'h0,        4'b0000, 32'h0,        1);
    issue(0, 3'd6, 32'h0000_0000, 32'h0,        0, 32'h0,        0, 0, 0, 1, 32'h0,        4'b0000, 32'h0,        1);
    issue(1, 3'd4, 32'h0000_0000, 32'h0,        0, 32'h0,        0, 0, 0, 1, 32'h0,        4'b0000, 32'h0,        1);
    issue(0, 3'd0, 32'h0000_0003, 32'h0,        0, 32'h7F000000, 0, 0, 1, 0, 32'h0000007F, 4'b1000, 32'h0,        3);
    // Timeout with grant but no response, then a late rvalid that must be ignored.
    issue(0, 3'd2, 32'h0000_0300, 32'h0,        0, 32'h0,        1, 0, 1, 1, 32'h0,        4'b1111, 32'h0,        9);
    cfg_no_rvalid = 1'b0;
    cfg_rdata     = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    rsp_pending = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("late_rvalid_done", 32'(bus.o_done), 32'd0);
      chk("late_rvalid_ld", bus.o_ld_data, 32'h0);
    end
    // Timeout with the grant never arriving.
    issue(0, 3'd2, 32'h0000_0304, 32'h0,       30, 32'h0,        0, 1, 1, 1, 32'h0,        4'b1111, 32'h0,        9);
    issue(0, 3'd4, 32'h0000_0002, 32'h0,        0, 32'h00C30000, 0, 0, 1, 0, 32'h000000C3, 4'b0100, 32'h0,        3);

    // Reset while the access waits in RESP.
    cfg_gnt_delay = 0;
    cfg_no_rvalid = 1'b1;
    bus_q.push_back('{addr: 32'h0000_0100, we: 1'b0, be: 4'b1111, wdata: 32'h0});
    @(negedge clk);
    bus.lsu_VALID = 1'b1;
    bus.i_st_mem  = 1'b0;
    bus.i_funct3  = 3'd2;
    bus.i_addr    = 32'h0000_0100;
    @(negedge clk);
    bus.lsu_VALID = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    $display("txn reset: asserted during response wait");
    chk("rst_resp_req", 32'(bus.o_mem_req), 32'd0);
    chk("rst_resp_stall", 32'(bus.o_stall), 32'd0);
    chk("rst_resp_done", 32'(bus.o_done), 32'd0);
    chk("rst_resp_ld", bus.o_ld_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cfg_no_rvalid = 1'b0;
    cfg_rdata     = 32'hAAAA_5555;
    @(posedge clk);
    #1;
    rsp_pending = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("rst_late_done", 32'(bus.o_done), 32'd0);
    end
    issue(0, 3'd2, 32'h0000_0100, 32'h0,        0, 32'h12345678, 0, 0, 1, 0, 32'h12345678, 4'b1111, 32'h0,        3);

    repeat (2) @(negedge clk);
    chk("resp_q_drained", 32'(resp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
